// File: rtl/address_range_generator.sv
// address_range_generator: emits base..bound at a fixed stride on a valid/ready stream, flagging the last beat.
module address_range_generator #(
  parameter int ADDR_WIDTH  = 8,
  parameter int ADDR_STRIDE = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_bound,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_last,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] bound;
  logic [ADDR_WIDTH:0]   next_addr;
  logic                  cmd_go;
  logic                  out_go;
  // one extra bit so a step past the top of the address space reads as beyond bound
  assign next_addr = {1'b0, addr} + (ADDR_WIDTH+1)'(ADDR_STRIDE);
  assign cmd_go    = state == IDLE && cmd_valid && cmd_base <= cmd_bound;
  assign out_go    = state == RUN && addr_ready;
  always_ff @(posedge clock)
    state <= clear ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (cmd_go ? RUN : IDLE) : (out_go && addr_last ? IDLE : RUN);
  always_comb begin
    cmd_ready  = state == IDLE;
    addr_valid = state == RUN;
    busy       = state == RUN;
    addr_last  = state == RUN && next_addr > {1'b0, bound};
  end
  always_ff @(posedge clock)
    if (clear) begin
      addr  <= '0;
      bound <= '0;
    end else if (cmd_go) begin
      addr  <= cmd_base;
      bound <= cmd_bound;
    end else if (out_go && !addr_last)
      addr <= next_addr[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_address_range_generator.sv
// tb_address_range_generator: directed + random sweeps on stride-1 and stride-4 instances against a list model.
module tb_address_range_generator;
  logic       clock = 0;
  logic       clear;
  logic [7:0] cmd_base[2], cmd_bound[2], addr[2];
  logic       cmd_valid[2], cmd_ready[2], addr_last[2], addr_valid[2], addr_ready[2], busy[2];
  int         compared = 0;
  int         mismatched = 0;

  always #5 clock = ~clock;

  address_range_generator #(.ADDR_WIDTH(8), .ADDR_STRIDE(1)) u_s1 (
    .clock(clock), .clear(clear), .cmd_base(cmd_base[0]), .cmd_bound(cmd_bound[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .addr(addr[0]), .addr_last(addr_last[0]),
    .addr_valid(addr_valid[0]), .addr_ready(addr_ready[0]), .busy(busy[0]));

  address_range_generator #(.ADDR_WIDTH(8), .ADDR_STRIDE(4)) u_s4 (
    .clock(clock), .clear(clear), .cmd_base(cmd_base[1]), .cmd_bound(cmd_bound[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .addr(addr[1]), .addr_last(addr_last[1]),
    .addr_valid(addr_valid[1]), .addr_ready(addr_ready[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_valid"}, {31'd0, addr_valid[d]}, 1'b0);
    chk({tag, "_ready"}, {31'd0, cmd_ready[d]}, 1'b1);
    chk({tag, "_busy"}, {31'd0, busy[d]}, 1'b0);
  endtask

  // mode 0: always ready, 1: fixed stall pattern then ready, 2: random ready
  task automatic sweep(input int d, input int base, input int bound, input int mode);
    int q[$];
    int stride;
    int a;
    int idx;
    int cyc;
    logic r;
    logic [6:0] pat;
    pat = 7'b1101001;
    stride = d == 0 ? 1 : 4;
    if (base <= bound) begin
      a = base;
      forever begin
        q.push_back(a);
        if (a + stride > bound) break;
        a += stride;
      end
    end
    @(negedge clock);
    chk("pre_cmd_ready", {31'd0, cmd_ready[d]}, 1'b1);
    cmd_base[d] = base[7:0];
    cmd_bound[d] = bound[7:0];
    cmd_valid[d] = 1;
    @(negedge clock);
    cmd_valid[d] = 0;
    if (q.size() == 0) begin
      chk_idle(d, "empty");
      @(negedge clock);
      chk_idle(d, "empty_hold");
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < q.size() && cyc < 2000) begin
      chk("run_valid", {31'd0, addr_valid[d]}, 1'b1);
      chk("run_addr", {24'd0, addr[d]}, q[idx]);
      chk("run_last", {31'd0, addr_last[d]}, {31'd0, idx == q.size() - 1});
      chk("run_busy", {31'd0, busy[d]}, 1'b1);
      chk("run_cmd_ready", {31'd0, cmd_ready[d]}, 1'b0);
      r = mode == 0 ? 1'b1 : mode == 1 ? (cyc < 7 ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
      addr_ready[d] = r;
      @(negedge clock);
      addr_ready[d] = 0;
      if (r) idx++;
      cyc++;
    end
    chk("beat_count", idx, q.size());
    chk_idle(d, "done");
  endtask

  initial begin
    int base;
    int bound;
    int d;
    clear = 1;
    for (int i = 0; i < 2; i++) begin
      cmd_base[i] = 0;
      cmd_bound[i] = 0;
      cmd_valid[i] = 0;
      addr_ready[i] = 0;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk_idle(i, "reset");
      chk("reset_addr", {24'd0, addr[i]}, 0);
      chk("reset_last", {31'd0, addr_last[i]}, 1'b0);
    end
    clear = 0;
    sweep(0, 'h10, 'h13, 0);
    sweep(0, 'h10, 'h13, 1);
    sweep(1, 'h01, 'h0A, 0);
    sweep(1, 'hF8, 'hFF, 0);
    sweep(0, 'h00, 'hFF, 0);
    sweep(0, 'h42, 'h42, 0);
    sweep(1, 'h42, 'h42, 1);
    sweep(0, 'h20, 'h1F, 0);
    sweep(1, 'hFF, 'hFF, 0);
    // clear mid-sweep after three beats
    @(negedge clock);
    cmd_base[0] = 'h00;
    cmd_bound[0] = 'h0F;
    cmd_valid[0] = 1;
    @(negedge clock);
    cmd_valid[0] = 0;
    addr_ready[0] = 1;
    repeat (3) @(negedge clock);
    chk("pre_clear_addr", {24'd0, addr[0]}, 'h03);
    clear = 1;
    @(negedge clock);
    clear = 0;
    addr_ready[0] = 0;
    chk_idle(0, "clear");
    chk("clear_addr", {24'd0, addr[0]}, 0);
    chk("clear_last", {31'd0, addr_last[0]}, 1'b0);
    @(negedge clock);
    chk_idle(0, "clear_hold");
    sweep(0, 'h30, 'h33, 0);
    for (int n = 0; n < 24; n++) begin
      d = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0 && base > 0) bound = base - 1;
      else begin
        bound = base + int'($urandom_range(0, 24));
        if (bound > 255) bound = 255;
      end
      sweep(d, base, bound, 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/address_range_generator.md
Name: address_range_generator

Overview:
Generates the address sequence that a base/bound range decoder matches. It accepts one range command (base, bound) and emits every address from base up to bound inclusive, at a fixed stride, on a valid/ready output stream, flagging the final address. It drives address-sweeping engines: memory scrub, register-file init and DMA walkers, into downstream decoders and RAMs.

Parameters:
ADDR_WIDTH, 8, width of base, bound and emitted address (1..32)
ADDR_STRIDE, 1, fixed increment between emitted addresses (>=1, < 2^ADDR_WIDTH)

Ports:
clock  input  1  single clock, all logic on rising edge
clear  input  1  synchronous active-high reset
cmd_base  input  ADDR_WIDTH  first address of range
cmd_bound  input  ADDR_WIDTH  last permissible address of range (inclusive)
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
addr  output  ADDR_WIDTH  current emitted address
addr_last  output  1  addr is final address of the range
addr_valid  output  1  addr/addr_last are valid
addr_ready  input  1  consumer accepts when addr_valid && addr_ready
busy  output  1  range sweep in progress (state RUN)

Behaviour:
- Interface: one clock (clock); clear is synchronous and active-high.
- Reset (clear=1 at an edge): state IDLE; cmd_ready=1, addr_valid=0, addr_last=0, busy=0, addr=0. clear overrides any handshake in the same cycle. clear mid-sweep abandons the range with no further addresses.
- States: IDLE, RUN.
- IDLE: cmd_ready=1, addr_valid=0, busy=0. On cmd handshake with cmd_base <= cmd_bound, latch the bound, load addr=cmd_base, and go to RUN. addr_valid=1 in the next cycle, so latency is 1 cycle from command to first address.
- Empty command (cmd_base > cmd_bound, unsigned): the command is accepted, no address is emitted, and the block stays IDLE with cmd_ready still 1.
- RUN: cmd_ready=0, busy=1, addr_valid=1.
  - addr and addr_last are held stable while addr_ready=0.
  - On an output handshake with addr_last=0: addr <= addr + ADDR_STRIDE.
  - On an output handshake with addr_last=1: go to IDLE, so cmd_ready=1 and addr_valid=0 the next cycle.
  - Throughput is one address per cycle while addr_ready=1.
- addr_last: computed from the current addr as next = addr + ADDR_STRIDE in ADDR_WIDTH+1 bits; addr_last = (next > bound).
  - The carry bit covers wrap-around: a sweep never wraps past 2^ADDR_WIDTH-1 back to 0.
  - A range whose last emitted address is below bound (stride overshoot) ends at the last address <= bound.
  - base == bound: exactly one address, with addr_last=1.
- addr_last is registered or combinational from registered state. It must be valid in the same cycle as addr, with no combinational path from addr_ready or the cmd inputs to any output.
- There is no command back-to-back with the final beat: the next command can be accepted one cycle after the last output handshake at the earliest.
- Full-range command (base=0, bound=2^ADDR_WIDTH-1, stride 1) emits 2^ADDR_WIDTH addresses with no width overflow.

Test Plan:
1. Basic sweep (ADDR_WIDTH=8, stride 1): cmd base=0x10, bound=0x13, addr_ready=1 -> addresses 0x10,0x11,0x12,0x13 on consecutive cycles starting 1 cycle after the command; addr_last only on 0x13; cmd_ready=1 the cycle after.
2. Backpressure: same command, addr_ready toggled 1,0,0,1,0,1,1 -> each address held stable while stalled; exactly 4 handshakes, no address skipped or repeated.
3. Stride and overshoot (stride 4): base=0x01, bound=0x0A -> 0x01,0x05,0x09, addr_last on 0x09.
4. Wrap guard (stride 4): base=0xF8, bound=0xFF -> 0xF8,0xFC, last on 0xFC, no 0x00. Full range at stride 1 -> 256 beats, last on 0xFF.
5. Edge commands: base=bound=0x42 -> single beat with addr_last=1. base=0x20, bound=0x1F -> accepted, addr_valid stays 0, cmd_ready stays 1.
6. Reset mid-sweep: clear pulsed during base=0x00, bound=0x0F after 3 beats -> next cycle addr_valid=0, busy=0, cmd_ready=1. A new command then starts cleanly at its base.
